// File: rtl/system_irq_ctrl.sv
// Avalon-MM interrupt controller: 8 prioritised sources (bit 0 highest), per-source
// edge/level capture, masking, and a claim / end-of-interrupt handshake with the CPU.
module system_irq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic [7:0]  irq_in,
    output logic [15:0] readdata,
    output logic        irq_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [2:0] A_PENDING    = 3'd0;
    localparam logic [2:0] A_MASK       = 3'd1;
    localparam logic [2:0] A_EDGE_SEL   = 3'd2;
    localparam logic [2:0] A_ACTIVE_ID  = 3'd3;
    localparam logic [2:0] A_FORCE      = 3'd4;
    localparam logic [2:0] A_CLAIM      = 3'd5;
    localparam logic [2:0] A_EOI        = 3'd6;
    localparam logic [2:0] A_IN_SERVICE = 3'd7;

    logic [1:0]  r_state;
    logic [7:0]  r_pending;
    logic [7:0]  r_mask;
    logic [7:0]  r_edge_sel;
    logic [7:0]  r_irq_d;
    logic [2:0]  r_in_service_id;
    logic [15:0] r_readdata;
    logic        r_irq_out;

    logic        w_wr;
    logic [7:0]  w_rise;
    logic [7:0]  w_eligible;
    logic        w_valid;
    logic [2:0]  w_id;
    logic        w_claim;
    logic        w_eoi_match;
    logic [7:0]  w_set;
    logic [7:0]  w_clr;
    logic [7:0]  w_pending_nxt;
    logic [1:0]  w_state_nxt;
    logic [15:0] w_rd_mux;

    assign w_wr       = chipselect & ~write_n;
    assign w_rise     = irq_in & ~r_irq_d;
    assign w_eligible = r_pending & r_mask;
    assign w_valid    = |w_eligible;
    assign w_claim    = w_wr && (address == A_CLAIM);
    assign w_eoi_match = w_wr && (address == A_EOI) && (r_state == ST_SERVICE)
                         && (writedata[2:0] == r_in_service_id);

    // Walk downward so the lowest set index wins.
    always_comb begin
        w_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_eligible[i]) w_id = 3'(i);
        end
    end

    // Edge-mode bits: set beats clear. Level-mode bits simply track the pin.
    always_comb begin
        w_set = w_rise;
        if (w_wr && (address == A_FORCE)) w_set = w_set | writedata[7:0];
        w_clr = 8'h00;
        if (w_wr && (address == A_PENDING)) w_clr = w_clr | writedata[7:0];
        if (w_eoi_match) w_clr = w_clr | (8'h01 << r_in_service_id);
        w_pending_nxt = (~r_edge_sel & irq_in)
                      | (r_edge_sel & ((r_pending & ~w_clr) | w_set));
    end

    // An empty eligible set in REQ takes priority: there is nothing left to claim.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_valid) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (!w_valid)     w_state_nxt = ST_IDLE;
                else if (w_claim) w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: if (w_eoi_match) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (address)
            A_PENDING:    w_rd_mux = {8'h00, r_pending};
            A_MASK:       w_rd_mux = {8'h00, r_mask};
            A_EDGE_SEL:   w_rd_mux = {8'h00, r_edge_sel};
            A_ACTIVE_ID:  w_rd_mux = {11'h000, w_valid, 1'b0, w_id};
            A_IN_SERVICE: w_rd_mux = {12'h000, (r_state == ST_SERVICE), r_in_service_id};
            default:      w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_pending       <= 8'h00;
            r_mask          <= 8'h00;
            r_edge_sel      <= 8'h00;
            r_irq_d         <= 8'h00;
            r_in_service_id <= 3'd0;
            r_readdata      <= 16'h0000;
            r_irq_out       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_irq_d    <= irq_in;
            r_readdata <= w_rd_mux;
            r_irq_out  <= (w_state_nxt == ST_REQ);
            if (w_wr && (address == A_MASK))     r_mask     <= writedata[7:0];
            if (w_wr && (address == A_EDGE_SEL)) r_edge_sel <= writedata[7:0];
            if ((r_state == ST_REQ) && (w_state_nxt == ST_SERVICE))
                r_in_service_id <= w_id;
        end
    end

    assign readdata = r_readdata;
    assign irq_out  = r_irq_out;

endmodule

// File: doc/system_irq_ctrl.md
SYSTEM_IRQ_CTRL -- requirements
Module: system_irq_ctrl

Interface
REQ-001 Parameters: none; source count fixed at 8, data width fixed at 16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  3  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-007 writedata  input  16  write data.
REQ-008 irq_in  input  8  interrupt sources; bit 0 = system timer irq, highest priority.
REQ-009 readdata  output  16  registered read data.
REQ-010 irq_out  output  1  registered interrupt request to CPU.

Function
REQ-011 Register map: 0 PENDING, 1 MASK, 2 EDGE_SEL, 3 ACTIVE_ID, 4 FORCE, 5 CLAIM, 6 EOI, 7 IN_SERVICE; only bits [7:0] of PENDING, MASK, EDGE_SEL and FORCE are used, and upper bits read 0.
REQ-012 readdata SHALL equal mux(address) registered every cycle; 1-cycle read latency; reads have no side effects; writes to 3 and 7 are ignored.
REQ-013 Edge detection: irq_d[7:0] <= irq_in every cycle; rise[i] = irq_in[i] & ~irq_d[i].
REQ-014 EDGE_SEL[i]=1 (edge mode): PENDING[i] set on rise[i] or FORCE write with writedata[i]=1; cleared by PENDING write with writedata[i]=1 (W1C) or by a matching EOI.
REQ-015 Set beats clear: a same-cycle set and clear leave PENDING[i]=1.
REQ-016 EDGE_SEL[i]=0 (level mode): PENDING[i] <= irq_in[i] every cycle; W1C, FORCE and EOI have no effect on that bit.
REQ-017 eligible = PENDING & MASK; ACTIVE_ID read = {11'b0, valid, 1'b0, id[2:0]}, valid = |eligible, id = lowest set index of eligible (0 when invalid).
REQ-018 FSM states IDLE, REQ, SERVICE; irq_out=1 only in REQ.
REQ-019 IDLE -> REQ when eligible != 0.
REQ-020 REQ -> IDLE when eligible becomes 0 (masked/cleared before claim).
REQ-021 REQ -> SERVICE on CLAIM write (any data); the current id is latched into in_service_id.
REQ-022 A CLAIM write in IDLE or SERVICE SHALL be ignored.
REQ-023 SERVICE -> IDLE on EOI write with writedata[2:0]==in_service_id; in edge mode this also clears PENDING[in_service_id]; a mismatched EOI SHALL be ignored.
REQ-024 IN_SERVICE read = {12'b0, in_svc, in_service_id}, in_svc=1 only in SERVICE.
REQ-025 irq_out is registered: it rises 1 cycle after eligible != 0 in IDLE and falls 1 cycle after a CLAIM write or after eligible clears.
REQ-026 New pending bits during SERVICE accumulate; no preemption; re-request after EOI via IDLE -> REQ.
REQ-027 MASK/EDGE_SEL writes take effect on the next cycle's eligible; switching a bit to level mode overwrites PENDING[i] with irq_in[i].

Reset
REQ-028 On reset_n=0, asynchronously: PENDING, MASK, EDGE_SEL, irq_d, readdata, in_service_id = 0; irq_out=0; state=IDLE.
REQ-029 Reset mid-SERVICE SHALL discard the claim; after release, irq_out stays 0 until a new eligible source exists.

Verification
REQ-030 Reset, then read addresses 0-7 -> all readdata 0, irq_out 0.
REQ-031 MASK=0x01, EDGE_SEL=0x01, pulse irq_in[0] one cycle -> PENDING=0x0001, irq_out=1 next cycle; ACTIVE_ID=0x0010; CLAIM -> irq_out 0; EOI data 0 -> PENDING 0, IDLE.
REQ-032 MASK=0xFF, EDGE_SEL=0xFF, FORCE 0x0C -> ACTIVE_ID=0x0012; CLAIM; EOI data 3 ignored (IN_SERVICE=0x000A); EOI 2 -> PENDING=0x0008, irq_out reasserts.
REQ-033 Edge mode: rise on irq_in[5] in the same cycle as W1C 0x0020 -> PENDING[5]=1.
REQ-034 Level mode bit 1, MASK=0x02: hold irq_in[1]=1 -> irq_out=1; W1C 0x0002 -> no change; drop irq_in[1] before claim -> irq_out 0 within 2 cycles.
REQ-035 Assert reset_n=0 during SERVICE -> immediately state IDLE, IN_SERVICE=0, irq_out=0.
